btn_debounce: RTL and testbench
===============================

# btn_debounce

Front-end conditioner for raw board push-buttons and switches. It synchronises the asynchronous input, rejects contact bounce with a stability counter, and produces a clean level plus single-cycle press, release and long-press events. It sits directly upstream of the one-shot pulse generator and counter logic, which consume `level`, `rise` and `long_press`.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronised samples required to accept a transition. Must be ≥2. Use 500000 on the 50 MHz board.
- `LONG_CYCLES`, default 64: cycles after `rise` at which `long_press` fires. Must be ≥1.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in` in 1: raw, asynchronous button level (1 = pressed).
- `level` out 1: debounced, registered button level.
- `rise` out 1: one-cycle pulse on an accepted press.
- `fall` out 1: one-cycle pulse on an accepted release.
- `long_press` out 1: one-cycle pulse, at most once per press.

## Operation
- 2-FF synchroniser: `in` → `s0` → `s1`. The FSM samples only `s1`.
- Stability counter `cnt`, width `$clog2(STABLE_CYCLES)+1`.
- Hold counter `hold`, width `$clog2(LONG_CYCLES)+1`. Saturating.
- FSM states: IDLE, PRESS_CHK, PRESSED, RELEASE_CHK.
  - IDLE: if `s1`=1, go to PRESS_CHK and set `cnt`←1. Otherwise stay.
  - PRESS_CHK:
    - `s1`=0: go to IDLE, `cnt`←0, no output.
    - `s1`=1 and `cnt`==STABLE_CYCLES−1: go to PRESSED, `rise`←1, `level`←1, `hold`←0.
    - Otherwise: `cnt`++.
  - PRESSED: if `s1`=0, go to RELEASE_CHK and set `cnt`←1.
  - RELEASE_CHK:
    - `s1`=1: go back to PRESSED. This is bounce; `hold` is not cleared.
    - `s1`=0 and `cnt`==STABLE_CYCLES−1: go to IDLE, `fall`←1, `level`←0.
    - Otherwise: `cnt`++.
- Hold counter:
  - Increments every cycle in PRESSED and RELEASE_CHK.
  - When it reaches LONG_CYCLES, `long_press`←1 for one cycle, then `hold` saturates. No refire.
  - Cleared on entry to IDLE.
- `rise`, `fall` and `long_press` are registered. Each is high for exactly one cycle and deasserts on the following edge.
- If `long_press` and the accepted release fall on the same edge, both `long_press` and `fall` assert in that cycle.

## Timing
- Reset (async, immediate):
  - `s0`=`s1`=0, state IDLE, `cnt`=`hold`=0.
  - `level`=`rise`=`fall`=`long_press`=0.
- Press latency: `in`=1 is first captured at edge 0. `s1` is high after edge 1, and the FSM's first sample is at edge 2. `rise` and `level` go high after edge STABLE_CYCLES+1.
- Release latency: symmetric, measured to `fall` and `level`=0.
- `long_press` goes high after edge (rise edge)+LONG_CYCLES.
- Any opposite sample inside a CHK state restarts qualification from scratch. A glitch shorter than STABLE_CYCLES never changes `level`.
- Reset asserted mid-press:
  - All outputs clear immediately.
  - No `fall` is produced.
  - If `in` is still high after `rst` drops, a full new qualification runs and yields a fresh `rise`.
- `in` held high across reset release: treated as a new press. `rise` fires after edge STABLE_CYCLES+1 counted from the first post-reset edge.

## Structure
- Shared package `lab_pkg`:
  - FSM state encoding localparams: IDLE=2'd0, PRESS_CHK=2'd1, PRESSED=2'd2, RELEASE_CHK=2'd3.
  - Board clock-frequency constant used to derive STABLE_CYCLES for synthesis.
- One sub-module: `sync_2ff` (1-bit, async active-high reset to 0). It is reused by other input paths.
- Counters and FSM stay in `btn_debounce`.

## Test plan
Bench parameters: STABLE_CYCLES=4, LONG_CYCLES=8.
- Clean press: `in` 0→1, sampled at edge 0, held 20 cycles.
  - Expect `rise`=1 only in the cycle after edge 5, and `level`=1 from edge 5.
  - Expect `long_press` pulse after edge 13, and no second pulse.
- Bounce rejection: `in` toggles 1,0,1,0 on successive cycles, then settles at 0.
  - Expect `level`, `rise` and `fall` to stay 0 throughout.
- Release bounce: while pressed, `in`=0 for 2 cycles, then 1, then 0 for ≥4 cycles.
  - Expect no `fall` on the short drop.
  - Expect `fall` 5 edges after the final 0 is captured, with `level`→0 on the same edge.
- Short press: press held 6 cycles.
  - Expect `rise` and then `fall`.
  - Expect `long_press` never asserted.
- Reset mid-press: assert `rst` while `level`=1, with `in` still high.
  - Expect all outputs 0 immediately and no `fall`.
  - After release, expect `rise` after edge 5 counted from the first post-reset edge.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the lab input-conditioning blocks.
// Holds the debouncer FSM encoding and the board clock constant used to size
// the debounce window for synthesis.
package lab_pkg;

  // Debouncer FSM state encoding
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  typedef enum logic [1:0] {
    IDLE        = ST_IDLE,
    PRESS_CHK   = ST_PRESS_CHK,
    PRESSED     = ST_PRESSED,
    RELEASE_CHK = ST_RELEASE_CHK
  } db_state_e;

  // Board clock and the debounce window it implies (10 ms at 50 MHz)
  localparam int unsigned BOARD_CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_MS         = 10;
  localparam int unsigned BOARD_STABLE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset, clears both stages to 0
//   d   - asynchronous input
//   q   - synchronised output (second stage)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;

  always_comb begin
    s0_d = d;
    s1_d = s0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign q = s1_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronises the raw input, accepts a transition
// only after STABLE_CYCLES identical samples, and emits a clean level plus
// one-cycle press, release and long-press events.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   in         - raw asynchronous button level (1 = pressed)
//   level      - debounced level
//   rise       - one-cycle pulse on accepted press
//   fall       - one-cycle pulse on accepted release
//   long_press - one-cycle pulse LONG_CYCLES after rise, once per press
module btn_debounce
  import lab_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic s1;

  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              long_q, long_d;
  logic              hold_run;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (s1)
  );

  // Next-state, counters and event pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    long_d  = 1'b0;

    // Hold time runs while pressed, including release qualification, and
    // saturates at LONG_CYCLES so long_press fires only on the way up.
    hold_run = (state_q == PRESSED) || (state_q == RELEASE_CHK);
    if (hold_run && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
      if (hold_q == HOLD_LAST) begin
        long_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (s1) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!s1) begin
          state_d = IDLE;
          cnt_d   = '0;
          hold_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          rise_d  = 1'b1;
          level_d = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s1) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        // A high sample here is bounce: resume the press, keep hold time.
        if (s1) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          fall_d  = 1'b1;
          level_d = 1'b0;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with STABLE_CYCLES=4, LONG_CYCLES=8. A run-length
// reference model predicts every output each cycle; scenario tasks add
// absolute timing checks on top.
module tb_btn_debounce;

  localparam int unsigned STABLE = 4;
  localparam int unsigned LONG   = 8;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic level, rise, fall, long_press;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .STABLE_CYCLES (STABLE),
    .LONG_CYCLES   (LONG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (btn_in),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  // Reference model: 2-sample delay line, then a run of samples that
  // disagree with the accepted level; STABLE of them flips the level.
  // Press age counts edges since the rise; long press exactly at LONG.
  bit m_s0, m_s1, m_samp, m_level, m_rise, m_fall, m_lp;
  int m_run, m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_lp = 0;
      m_run = 0; m_age = 0;
    end else begin
      m_samp = m_s1;
      m_s1   = m_s0;
      m_s0   = btn_in;
      m_rise = 0; m_fall = 0; m_lp = 0;
      if (m_level) begin
        m_age = m_age + 1;
        if (m_age == LONG) m_lp = 1;
      end
      if (m_samp != m_level) m_run = m_run + 1;
      else                   m_run = 0;
      if (m_run == STABLE) begin
        m_run   = 0;
        m_level = !m_level;
        if (m_level) begin
          m_rise = 1;
          m_age  = 0;
        end else begin
          m_fall = 1;
        end
      end
    end
  end

  task automatic tick(input logic v);
    btn_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 1'b0;
    #1;
    vectors++;
    if ({level, rise, fall, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %b want 0000", {level, rise, fall, long_press});
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0);
      vectors++;
      if ({level, rise, fall, long_press} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b want 0000", k, {level, rise, fall, long_press});
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_at = -1, lp_at = -1, rise_n = 0, lp_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1);
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL clean_press cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
      if (rise === 1'b1) begin rise_at = k; rise_n++; end
      if (long_press === 1'b1) begin lp_at = k; lp_n++; end
    end
    vectors++;
    if (rise_n !== 1 || rise_at !== 5) begin
      errors++;
      $display("FAIL clean_rise_edge got n=%0d at=%0d want n=1 at=5", rise_n, rise_at);
    end
    vectors++;
    if (lp_n !== 1 || lp_at !== 13) begin
      errors++;
      $display("FAIL clean_long_edge got n=%0d at=%0d want n=1 at=13", lp_n, lp_at);
    end
  endtask

  task automatic test_release_bounce();
    int fall_at = -1, fall_n = 0;
    logic pre [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      tick(pre[k]);
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL rel_bounce_pre cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
      if (fall === 1'b1) fall_n++;
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL rel_bounce cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
      if (fall === 1'b1) begin fall_at = k; fall_n++; end
      if (k == 5) begin
        vectors++;
        if (level !== 1'b0) begin
          errors++;
          $display("FAIL rel_level_drop got %b want 0", level);
        end
      end
    end
    vectors++;
    if (fall_n !== 1 || fall_at !== 5) begin
      errors++;
      $display("FAIL rel_fall_edge got n=%0d at=%0d want n=1 at=5", fall_n, fall_at);
    end
  endtask

  task automatic test_bounce();
    logic seq [14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 14; k++) begin
      tick(seq[k]);
      vectors++;
      if ({level, rise, fall} !== 3'b000) begin
        errors++;
        $display("FAIL bounce_quiet cyc %0d got %b want 000", k, {level, rise, fall});
      end
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL bounce_model cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
    end
  endtask

  task automatic test_short_press();
    int rise_at = -1, fall_at = -1, rise_n = 0, fall_n = 0, lp_n = 0;
    for (int k = 0; k < 18; k++) begin
      tick((k < 6) ? 1'b1 : 1'b0);
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL short_press cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
      if (rise === 1'b1) begin rise_at = k; rise_n++; end
      if (fall === 1'b1) begin fall_at = k; fall_n++; end
      if (long_press === 1'b1) lp_n++;
    end
    vectors++;
    if (rise_n !== 1 || rise_at !== 5 || fall_n !== 1 || fall_at !== 11) begin
      errors++;
      $display("FAIL short_edges got rise %0d@%0d fall %0d@%0d want 1@5 1@11",
               rise_n, rise_at, fall_n, fall_at);
    end
    vectors++;
    if (lp_n !== 0) begin
      errors++;
      $display("FAIL short_no_long got %0d pulses want 0", lp_n);
    end
  endtask

  task automatic test_reset_mid_press();
    int rise_at = -1, rise_n = 0, fall_n = 0;
    for (int k = 0; k < 8; k++) tick(1'b1);
    vectors++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_level got %b want 1", level);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({level, rise, fall, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_clear got %b want 0000", {level, rise, fall, long_press});
    end
    tick(1'b1);
    tick(1'b1);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1);
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL midrst_req cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
      if (rise === 1'b1) begin rise_at = k; rise_n++; end
      if (fall === 1'b1) fall_n++;
    end
    vectors++;
    if (rise_n !== 1 || rise_at !== 5 || fall_n !== 0) begin
      errors++;
      $display("FAIL midrst_edges got rise %0d@%0d fall %0d want 1@5 fall 0",
               rise_n, rise_at, fall_n);
    end
  endtask

  task automatic test_random();
    int left = 0;
    logic v = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (left == 0) begin
        v    = ~v;
        left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : $urandom_range(1, 6);
      end
      left--;
      tick(v);
      vectors++;
      if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", k,
                 {level, rise, fall, long_press}, {m_level, m_rise, m_fall, m_lp});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_bounce();
    test_short_press();
    test_random();
    for (int k = 0; k < 12; k++) tick(1'b0);
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
